load_store_unit: RTL

Initiator side of the data-memory load/store interface: accepts one RV32 load or store per request from the CPU execute/memory stage and drives the word-addressed data memory (`load_store`/`op`/`mem_done` handshake). Handles byte/halfword sizing (sign/zero extension on loads, read-modify-write on sub-word stores), alignment checking and a response timeout. Sits between the pipeline's memory stage and the data memory block.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 size codes, memory
// opcodes, FSM state encoding and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] MEM_OP_LOAD  = 2'b00;
    localparam logic [1:0] MEM_OP_STORE = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_RD = 3'd1,
        ST_WAIT_RD  = 3'd2,
        ST_ISSUE_WR = 3'd3,
        ST_WAIT_WR  = 3'd4,
        ST_RESP     = 3'd5
    } lsu_state_e;

    // High when the request can never reach memory: unknown size code,
    // unsigned size on a store, or an address not aligned to the size.
    function automatic logic req_illegal(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling for sub-word accesses: extracts and extends the
// addressed lane of a read word for loads, and merges store bytes into a
// read word for read-modify-write stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_wdata_o
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    // Select the addressed byte/half of the read word and extend it.
    always_comb begin
        lane_byte_s = 8'h00;
        lane_half_s = 16'h0000;
        load_data_o = 32'h0000_0000;
        case (addr_lo_i)
            2'b00:   lane_byte_s = rdata_i[7:0];
            2'b01:   lane_byte_s = rdata_i[15:8];
            2'b10:   lane_byte_s = rdata_i[23:16];
            2'b11:   lane_byte_s = rdata_i[31:24];
            default: lane_byte_s = 8'h00;
        endcase
        lane_half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    load_data_o = {{24{lane_byte_s[7]}}, lane_byte_s};
            F3_H:    load_data_o = {{16{lane_half_s[15]}}, lane_half_s};
            F3_W:    load_data_o = rdata_i;
            F3_BU:   load_data_o = {24'h00_0000, lane_byte_s};
            F3_HU:   load_data_o = {16'h0000, lane_half_s};
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Overlay the low store byte/half onto the read word at the addressed lane.
    always_comb begin
        merged_wdata_o = rdata_i;
        case (funct3_i)
            F3_B: begin
                case (addr_lo_i)
                    2'b00:   merged_wdata_o[7:0]   = store_data_i[7:0];
                    2'b01:   merged_wdata_o[15:8]  = store_data_i[7:0];
                    2'b10:   merged_wdata_o[23:16] = store_data_i[7:0];
                    2'b11:   merged_wdata_o[31:24] = store_data_i[7:0];
                    default: merged_wdata_o = rdata_i;
                endcase
            end
            F3_H: begin
                if (addr_lo_i[1]) begin
                    merged_wdata_o[31:16] = store_data_i;
                end else begin
                    merged_wdata_o[15:0] = store_data_i;
                end
            end
            default: merged_wdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory load/store interface. One request at a
// time: legality check, optional read (loads and sub-word stores), optional
// write, response timeout, one-cycle done pulse. All outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_load_store,
    output logic [1:0]  mem_op,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] store_data_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] load_data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_load_store_q;
    logic [1:0]  mem_op_q;

    logic [31:0] ext_load_s;
    logic [31:0] merged_wdata_s;

    lsu_align u_align (
        .funct3_i       (funct3_q),
        .addr_lo_i      (addr_lo_q),
        .rdata_i        (mem_rdata),
        .store_data_i   (store_data_q),
        .load_data_o    (ext_load_s),
        .merged_wdata_o (merged_wdata_s)
    );

    // Request FSM with timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            is_store_q       <= 1'b0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            store_data_q     <= 16'h0000;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            load_data_q      <= 32'h0000_0000;
            mem_addr_q       <= 32'h0000_0000;
            mem_wdata_q      <= 32'h0000_0000;
            mem_load_store_q <= 1'b0;
            mem_op_q         <= MEM_OP_LOAD;
        end else begin
            // Pulsed outputs default low; states below raise them for one cycle.
            mem_load_store_q <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        is_store_q   <= is_store;
                        funct3_q     <= funct3;
                        addr_lo_q    <= addr[1:0];
                        store_data_q <= store_data[15:0];
                        mem_addr_q   <= {addr[31:2], 2'b00};
                        busy_q       <= 1'b1;
                        if (req_illegal(is_store, funct3, addr[1:0])) begin
                            state_q <= ST_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (is_store && (funct3 == F3_W)) begin
                            state_q          <= ST_ISSUE_WR;
                            mem_wdata_q      <= store_data;
                            mem_load_store_q <= 1'b1;
                            mem_op_q         <= MEM_OP_STORE;
                        end else begin
                            state_q          <= ST_ISSUE_RD;
                            mem_load_store_q <= 1'b1;
                            mem_op_q         <= MEM_OP_LOAD;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE_RD: begin
                    state_q <= ST_WAIT_RD;
                    cnt_q   <= '0;
                end
                ST_ISSUE_WR: begin
                    state_q <= ST_WAIT_WR;
                    cnt_q   <= '0;
                end
                ST_WAIT_RD: begin
                    if (mem_done) begin
                        if (is_store_q) begin
                            // Sub-word store: write back the merged word.
                            mem_wdata_q      <= merged_wdata_s;
                            state_q          <= ST_ISSUE_WR;
                            mem_load_store_q <= 1'b1;
                            mem_op_q         <= MEM_OP_STORE;
                        end else begin
                            load_data_q <= ext_load_s;
                            state_q     <= ST_RESP;
                            done_q      <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT_WR: begin
                    if (mem_done) begin
                        state_q <= ST_RESP;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign load_data      = load_data_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_load_store = mem_load_store_q;
    assign mem_op         = mem_op_q;

endmodule
